wb_dual_writeback: RTL and testbench
====================================

// Module: wb_dual_writeback
// PURPOSE
//  Writeback stage for the dual-issue pipeline; write-side driver of the 2W/4R register file.
//  - Registers the two MEM-stage results (lane 1 = older, lane 2 = younger).
//  - Generates the WE/WA/WD write-port signals, including same-address collision resolution.
//  - Bypasses same-cycle writes onto the four read ports.
//  - Counts retired instructions.
// PARAMETERS
//  DW  32  data width of register values
//  AW  5   register address width (2**AW registers; address 0 reads as zero)
//  CW  32  width of RetireCnt
// PORTS
//  Clk        in   1   clock, all state updates on posedge
//  Reset      in   1   synchronous, active-high reset
//  Stall      in   1   hold the WB register; suppress writes this cycle
//  Flush      in   1   discard the incoming MEM results (load bubble)
//  MV1,MV2    in   1   MEM lane valid
//  MRW1,MRW2  in   1   MEM lane register-write request
//  MWA1,MWA2  in   AW  MEM lane destination address
//  MWD1,MWD2  in   DW  MEM lane result data
//  WE1,WE2    out  1   register-file write enables
//  WA1,WA2    out  AW  register-file write addresses
//  WD1,WD2    out  DW  register-file write data
//  A11,A21,A12,A22      in   AW  decode-stage read addresses (also drive the reg file)
//  RF11,RF21,RF12,RF22  in   DW  raw register-file read data
//  RD11,RD21,RD12,RD22  out  DW  bypassed read data to decode
//  RetireCnt  out  CW  retired-instruction count
// BEHAVIOUR
//  WB register fields: V1,V2,RW1,RW2,WA1,WA2,WD1,WD2.
//  Posedge priority, highest first:
//  1. Reset: all fields <= 0 and RetireCnt <= 0.
//  2. Stall: hold all fields.
//  3. Flush: V1,V2,RW1,RW2 <= 0.
//  4. Otherwise: capture the M* inputs.
//  Latency: a MEM result appears on WE/WA/WD exactly 1 cycle after capture.
//  Reset mid-operation drops any pending writes.
//  Enables (combinational from the WB register):
//  - e1 = V1 & RW1 & (WA1!=0); e2 = V2 & RW2 & (WA2!=0).
//  - Collision: e1 & e2 & (WA1==WA2). Younger lane wins: WE1 = e1 & ~collision & ~Stall.
//  - WE2 = e2 & ~Stall.
//  - Writes to r0 never assert WE.
//  - WA/WD outputs always reflect the WB register, even when WE=0.
//  - After Reset all outputs are 0, except RD* (which follow RF*).
//  Stall semantics:
//  - The entry is written on the first cycle with Stall=0; it is written once only.
//  - Stall=1 together with Reset=1: Reset wins.
//  Bypass, per read port Axy:
//  - Axy==0 -> RDxy = 0.
//  - Else if WE2 & (WA2==Axy) -> WD2.
//  - Else if WE1 & (WA1==Axy) -> WD1.
//  - Else -> RFxy.
//  - Purely combinational; no added latency.
//  - Uses the gated WE, so there is no bypass during Stall. The reg file still holds the old value then, which is correct.
//  RetireCnt:
//  - On a posedge with Reset=0 and Stall=0: RetireCnt += V1 + V2 (0, 1 or 2).
//  - Counts valid instructions whether or not they write a register.
//  - Wraps modulo 2**CW; no saturation.
//  - Updates from the WB register contents before recapture, so each entry is counted exactly once.
// TESTING
//  1. Reset 2 cycles -> WE1=WE2=0, RetireCnt=0, RD11=RF11.
//  2. MV1/MRW1: WA=5, WD=0xAAAA; MV2/MRW2: WA=9, WD=0x5555 -> next cycle:
//     - WE1=WE2=1 with WA/WD matching.
//     - A11=5 -> RD11=0xAAAA; A22=9 -> RD22=0x5555.
//     - RetireCnt increases by 2.
//  3. Both lanes write r7 (0x1111 / 0x2222) -> WE1=0, WE2=1; A12=7 -> RD12=0x2222.
//  4. Lane 1 writes r0 with 0xDEAD -> WE1=0; A11=0 -> RD11=0 while RF11=0xFFFF.
//  5. Entry WA=3, WD=0x33, then Stall=1 for 3 cycles -> WE1=0 and RetireCnt frozen throughout.
//     Stall drops -> WE1=1 for exactly 1 cycle; RetireCnt +1.
//  6. Flush with MV1=MV2=1 -> next cycle WE1=WE2=0 and RetireCnt unchanged.
//     Separately, preload RetireCnt=2**CW-1, then retire 2 -> RetireCnt=1.

Source files
------------

// File: rtl/wb_dual_writeback_if.sv
// Bundles every non-clock signal of the dual-issue writeback stage:
// MEM-stage results in, register-file write port out, and bypassed read ports.
interface wb_dual_writeback_if #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 32
);
    // pipeline control
    logic          Stall;
    logic          Flush;

    // MEM-stage results, lane 1 older, lane 2 younger
    logic          MV1, MV2;
    logic          MRW1, MRW2;
    logic [AW-1:0] MWA1, MWA2;
    logic [DW-1:0] MWD1, MWD2;

    // register-file write port
    logic          WE1, WE2;
    logic [AW-1:0] WA1, WA2;
    logic [DW-1:0] WD1, WD2;

    // decode-stage read ports
    logic [AW-1:0] A11, A21, A12, A22;
    logic [DW-1:0] RF11, RF21, RF12, RF22;
    logic [DW-1:0] RD11, RD21, RD12, RD22;

    // retirement count
    logic [CW-1:0] RetireCnt;

    // pipeline/decode side: drives MEM results and read addresses, consumes writes
    modport master (
        output Stall, Flush,
        output MV1, MV2, MRW1, MRW2, MWA1, MWA2, MWD1, MWD2,
        output A11, A21, A12, A22, RF11, RF21, RF12, RF22,
        input  WE1, WE2, WA1, WA2, WD1, WD2,
        input  RD11, RD21, RD12, RD22,
        input  RetireCnt
    );

    // writeback stage side
    modport slave (
        input  Stall, Flush,
        input  MV1, MV2, MRW1, MRW2, MWA1, MWA2, MWD1, MWD2,
        input  A11, A21, A12, A22, RF11, RF21, RF12, RF22,
        output WE1, WE2, WA1, WA2, WD1, WD2,
        output RD11, RD21, RD12, RD22,
        output RetireCnt
    );
endinterface

// File: rtl/wb_dual_writeback.sv
// Writeback stage of the dual-issue pipeline. Holds the two MEM results in the
// WB register, drives the 2-write-port register file (younger lane wins on a
// same-address collision), forwards same-cycle writes onto the four decode
// read ports, and counts retired instructions.
module wb_dual_writeback #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 32
) (
    input logic            Clk,
    input logic            Reset,
    wb_dual_writeback_if.slave bus
);

    // WB register fields
    logic          wb_v1, wb_v2;
    logic          wb_rw1, wb_rw2;
    logic [AW-1:0] wb_wa1, wb_wa2;
    logic [DW-1:0] wb_wd1, wb_wd2;

    logic [CW-1:0] retire_cnt;
    logic [1:0]    retire_inc;

    logic          en1, en2;
    logic          collision;
    logic          we1, we2;

    logic [DW-1:0] rd11, rd21, rd12, rd22;

    // Pick the newest in-flight value for one read port; r0 is hardwired to zero.
    function automatic logic [DW-1:0] bypass(
        input logic [AW-1:0] addr,
        input logic [DW-1:0] rf_data,
        input logic          w1,
        input logic [AW-1:0] a1,
        input logic [DW-1:0] d1,
        input logic          w2,
        input logic [AW-1:0] a2,
        input logic [DW-1:0] d2
    );
        logic [DW-1:0] result;
        if (addr == '0) begin
            result = '0;
        end else if (w2 && (a2 == addr)) begin
            result = d2;
        end else if (w1 && (a1 == addr)) begin
            result = d1;
        end else begin
            result = rf_data;
        end
        return result;
    endfunction

    // WB register: reset beats stall, stall holds everything, flush only kills valids/requests
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wb_v1  <= 1'b0;
            wb_v2  <= 1'b0;
            wb_rw1 <= 1'b0;
            wb_rw2 <= 1'b0;
            wb_wa1 <= '0;
            wb_wa2 <= '0;
            wb_wd1 <= '0;
            wb_wd2 <= '0;
        end else if (!bus.Stall) begin
            if (bus.Flush) begin
                wb_v1  <= 1'b0;
                wb_v2  <= 1'b0;
                wb_rw1 <= 1'b0;
                wb_rw2 <= 1'b0;
            end else begin
                wb_v1  <= bus.MV1;
                wb_v2  <= bus.MV2;
                wb_rw1 <= bus.MRW1;
                wb_rw2 <= bus.MRW2;
                wb_wa1 <= bus.MWA1;
                wb_wa2 <= bus.MWA2;
                wb_wd1 <= bus.MWD1;
                wb_wd2 <= bus.MWD2;
            end
        end
    end

    // number of valid entries leaving the WB register this cycle
    assign retire_inc = {1'b0, wb_v1} + {1'b0, wb_v2};

    // Retire counter: counts the entries as they leave, so a stalled entry is counted once
    always_ff @(posedge Clk) begin
        if (Reset) begin
            retire_cnt <= '0;
        end else if (!bus.Stall) begin
            retire_cnt <= retire_cnt + CW'(retire_inc);
        end
    end

    // Write enables: r0 never written, younger lane wins a same-address collision
    always_comb begin
        en1       = wb_v1 & wb_rw1 & (wb_wa1 != '0);
        en2       = wb_v2 & wb_rw2 & (wb_wa2 != '0);
        collision = en1 & en2 & (wb_wa1 == wb_wa2);
        we1       = en1 & ~collision & ~bus.Stall;
        we2       = en2 & ~bus.Stall;
    end

    // Read-port bypass uses the gated enables, so nothing is forwarded while stalled
    always_comb begin
        rd11 = bypass(bus.A11, bus.RF11, we1, wb_wa1, wb_wd1, we2, wb_wa2, wb_wd2);
        rd21 = bypass(bus.A21, bus.RF21, we1, wb_wa1, wb_wd1, we2, wb_wa2, wb_wd2);
        rd12 = bypass(bus.A12, bus.RF12, we1, wb_wa1, wb_wd1, we2, wb_wa2, wb_wd2);
        rd22 = bypass(bus.A22, bus.RF22, we1, wb_wa1, wb_wd1, we2, wb_wa2, wb_wd2);
    end

    assign bus.WE1       = we1;
    assign bus.WE2       = we2;
    assign bus.WA1       = wb_wa1;
    assign bus.WA2       = wb_wa2;
    assign bus.WD1       = wb_wd1;
    assign bus.WD2       = wb_wd2;
    assign bus.RD11      = rd11;
    assign bus.RD21      = rd21;
    assign bus.RD12      = rd12;
    assign bus.RD22      = rd22;
    assign bus.RetireCnt = retire_cnt;

endmodule

// File: tb/tb_wb_dual_writeback.sv
// Directed, table-driven bench for wb_dual_writeback. Each table row is one
// clock cycle: the inputs driven after a falling edge and the outputs expected
// just after, which reflect the entry captured on the previous rising edge.
// RetireCnt is built 8 bits wide so the wrap-around case is reachable quickly.
module tb_wb_dual_writeback;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 8;
    localparam int NVEC = 11;

    typedef struct {
        logic [31:0] stall, flush;
        logic [31:0] v1, rw1, wa1, wd1;
        logic [31:0] v2, rw2, wa2, wd2;
        logic [31:0] a11, rf11, a21, rf21, a12, rf12, a22, rf22;
        logic [31:0] we1, we2, ea1, ea2, ed1, ed2;
        logic [31:0] rd11, rd21, rd12, rd22;
        logic [31:0] cnt;
    } vec_t;

    logic Clk;
    logic Reset;
    int   n_checks;
    int   n_miss;
    vec_t vec [NVEC];

    wb_dual_writeback_if #(.DW(DW), .AW(AW), .CW(CW)) bus ();

    wb_dual_writeback #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    // free-running clock
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic set_mem(input logic stall, input logic flush,
                           input logic v1, input logic rw1, input logic [AW-1:0] wa1, input logic [DW-1:0] wd1,
                           input logic v2, input logic rw2, input logic [AW-1:0] wa2, input logic [DW-1:0] wd2);
        bus.Stall = stall;
        bus.Flush = flush;
        bus.MV1   = v1;
        bus.MRW1  = rw1;
        bus.MWA1  = wa1;
        bus.MWD1  = wd1;
        bus.MV2   = v2;
        bus.MRW2  = rw2;
        bus.MWA2  = wa2;
        bus.MWD2  = wd2;
    endtask

    task automatic apply_stimulus(input vec_t v);
        set_mem(v.stall[0], v.flush[0], v.v1[0], v.rw1[0], v.wa1[AW-1:0], v.wd1,
                v.v2[0], v.rw2[0], v.wa2[AW-1:0], v.wd2);
        bus.A11  = v.a11[AW-1:0];
        bus.RF11 = v.rf11;
        bus.A21  = v.a21[AW-1:0];
        bus.RF21 = v.rf21;
        bus.A12  = v.a12[AW-1:0];
        bus.RF12 = v.rf12;
        bus.A22  = v.a22[AW-1:0];
        bus.RF22 = v.rf22;
    endtask

    task automatic check_vector(input int idx, input vec_t v);
        check_output($sformatf("v%0d.WE1", idx), 32'(bus.WE1), v.we1);
        check_output($sformatf("v%0d.WE2", idx), 32'(bus.WE2), v.we2);
        check_output($sformatf("v%0d.WA1", idx), 32'(bus.WA1), v.ea1);
        check_output($sformatf("v%0d.WA2", idx), 32'(bus.WA2), v.ea2);
        check_output($sformatf("v%0d.WD1", idx), bus.WD1, v.ed1);
        check_output($sformatf("v%0d.WD2", idx), bus.WD2, v.ed2);
        check_output($sformatf("v%0d.RD11", idx), bus.RD11, v.rd11);
        check_output($sformatf("v%0d.RD21", idx), bus.RD21, v.rd21);
        check_output($sformatf("v%0d.RD12", idx), bus.RD12, v.rd12);
        check_output($sformatf("v%0d.RD22", idx), bus.RD22, v.rd22);
        check_output($sformatf("v%0d.RetireCnt", idx), 32'(bus.RetireCnt), v.cnt);
    endtask

    initial begin
        n_checks = 0;
        n_miss   = 0;

        // stall,flush, v1,rw1,wa1,wd1, v2,rw2,wa2,wd2, a11,rf11,a21,rf21,a12,rf12,a22,rf22, we1,we2,wa1,wa2,wd1,wd2, rd11,rd21,rd12,rd22, cnt
        // two independent writes enter
        vec[0]  = '{0,0, 1,1,5,'hAAAA, 1,1,9,'h5555, 0,0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0, 0};
        // both writes visible and forwarded; a same-address pair enters
        vec[1]  = '{0,0, 1,1,7,'h1111, 1,1,7,'h2222, 5,'hFFFF,4,'hBEEF,3,'h1357,9,0, 1,1,5,9,'hAAAA,'h5555, 'hAAAA,'hBEEF,'h1357,'h5555, 0};
        // collision: lane 2 wins; lane-1 r0 write and invalid lane 2 enter
        vec[2]  = '{0,0, 1,1,0,'hDEAD, 0,1,6,'h6666, 7,0,0,'hFFFF,7,0,8,'h88, 0,1,7,7,'h1111,'h2222, 'h2222,0,'h2222,'h88, 2};
        // r0 write suppressed and reads as zero; entry r3 plus a valid non-writing lane 2 enters
        vec[3]  = '{0,0, 1,1,3,'h33, 1,0,3,'h44, 0,'hFFFF,6,'h61,0,0,0,0, 0,0,0,6,'hDEAD,'h6666, 0,'h61,0,0, 4};
        // stalled three cycles: no write, no forward, count frozen
        vec[4]  = '{1,0, 1,1,10,'hAB, 1,1,11,'hCD, 3,'h30,0,0,0,0,0,0, 0,0,3,3,'h33,'h44, 'h30,0,0,0, 5};
        vec[5]  = '{1,0, 1,1,10,'hAB, 1,1,11,'hCD, 3,'h30,0,0,0,0,0,0, 0,0,3,3,'h33,'h44, 'h30,0,0,0, 5};
        vec[6]  = '{1,0, 1,1,10,'hAB, 1,1,11,'hCD, 3,'h30,0,0,0,0,0,0, 0,0,3,3,'h33,'h44, 'h30,0,0,0, 5};
        // stall released: r3 written once; incoming lanes flushed
        vec[7]  = '{0,1, 1,1,12,'hC0C0, 1,1,13,'hD0D0, 3,'h30,0,0,0,0,0,0, 1,0,3,3,'h33,'h44, 'h33,0,0,0, 5};
        // flushed bubble: no writes, count takes the two stalled entries
        vec[8]  = '{0,0, 1,1,12,'hC0C0, 1,1,13,'hD0D0, 3,'h30,0,0,0,0,0,0, 0,0,3,3,'h33,'h44, 'h30,0,0,0, 7};
        // post-flush pair writes and forwards
        vec[9]  = '{0,0, 0,0,0,0, 0,0,0,0, 13,1,12,2,0,0,0,0, 1,1,12,13,'hC0C0,'hD0D0, 'hD0D0,'hC0C0,0,0, 7};
        // idle
        vec[10] = '{0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0, 9};

        // reset for two cycles with a read port pointed at a live register
        Reset = 1'b1;
        set_mem(0, 0, 0, 0, '0, '0, 0, 0, '0, '0);
        bus.A11  = 5'd3;
        bus.RF11 = 32'h1234;
        bus.A21  = '0;
        bus.RF21 = '0;
        bus.A12  = '0;
        bus.RF12 = '0;
        bus.A22  = '0;
        bus.RF22 = '0;
        repeat (2) @(negedge Clk);
        #1;
        check_output("reset.WE1", 32'(bus.WE1), 0);
        check_output("reset.WE2", 32'(bus.WE2), 0);
        check_output("reset.WA1", 32'(bus.WA1), 0);
        check_output("reset.WD2", bus.WD2, 0);
        check_output("reset.RetireCnt", 32'(bus.RetireCnt), 0);
        check_output("reset.RD11", bus.RD11, 32'h1234);
        Reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge Clk);
            apply_stimulus(vec[i]);
            #1;
            check_vector(i, vec[i]);
        end

        // reset arriving with stall drops a pending write and clears the count
        @(negedge Clk);
        set_mem(0, 0, 1, 1, 5'd20, 32'h77, 0, 0, '0, '0);
        @(negedge Clk);
        Reset = 1'b1;
        set_mem(1, 0, 0, 0, '0, '0, 0, 0, '0, '0);
        @(negedge Clk);
        Reset = 1'b0;
        set_mem(0, 0, 0, 0, '0, '0, 0, 0, '0, '0);
        #1;
        check_output("midreset.WE1", 32'(bus.WE1), 0);
        check_output("midreset.WA1", 32'(bus.WA1), 0);
        check_output("midreset.WD1", bus.WD1, 0);
        check_output("midreset.RetireCnt", 32'(bus.RetireCnt), 0);
        @(negedge Clk);
        #1;
        check_output("midreset.late_WE1", 32'(bus.WE1), 0);

        // retire 255 (127 pairs then a single), then two more to wrap to 1
        for (int k = 0; k < 127; k++) begin
            @(negedge Clk);
            set_mem(0, 0, 1, 0, '0, '0, 1, 0, '0, '0);
        end
        @(negedge Clk);
        set_mem(0, 0, 1, 0, '0, '0, 0, 0, '0, '0);
        @(negedge Clk);
        set_mem(0, 0, 0, 0, '0, '0, 0, 0, '0, '0);
        @(negedge Clk);
        #1;
        check_output("wrap.full", 32'(bus.RetireCnt), 255);
        @(negedge Clk);
        set_mem(0, 0, 1, 0, '0, '0, 1, 0, '0, '0);
        #1;
        check_output("wrap.hold", 32'(bus.RetireCnt), 255);
        @(negedge Clk);
        set_mem(0, 0, 0, 0, '0, '0, 0, 0, '0, '0);
        @(negedge Clk);
        #1;
        check_output("wrap.rollover", 32'(bus.RetireCnt), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
        $finish;
    end

endmodule
